// File: rtl/circle_list_pkg.sv
// rtl/circle_list_pkg.sv - shared state encoding, parameter defaults and pointer wrap helper
package circle_list_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_CHECK,
        ST_RESP
    } scan_state_t;

    // Next cell index around the ring: the last cell wraps to 0, never to depth.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/circle_list_scan_ctrl_if.sv
// rtl/circle_list_scan_ctrl_if.sv - controller lookup port: request handshake and one-cycle response
interface circle_list_scan_ctrl_if #(
    parameter int DW = circle_list_pkg::DW_DEF,
    parameter int AW = circle_list_pkg::AW_DEF
) ();

    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_key;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_valid, req_key,
        input  req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_data
    );

    modport slave (
        input  req_valid, req_key,
        output req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_data
    );

endinterface

// File: rtl/circle_list_ptr_cnt.sv
// rtl/circle_list_ptr_cnt.sv - wrapping scan pointer, step counter and start pointer (CIRCLE_LIST_RESUME_EN)
module circle_list_ptr_cnt
    import circle_list_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic          hit,
    output logic [AW-1:0] ptr,
    output logic [AW-1:0] start,
    output logic          done
);

    // One bit wider than the pointer so a full DEPTH=2^AW scan cannot overflow.
    logic [AW:0] step_cnt;

    // The advance in progress is the DEPTH-th evaluated cell.
    assign done = (step_cnt == (AW+1)'(DEPTH - 1));

    // Pointer and step count: load from the start pointer, then step with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            step_cnt <= '0;
        end else if (load) begin
            ptr      <= start;
            step_cnt <= '0;
        end else if (advance) begin
            step_cnt <= step_cnt + 1'b1;
            if (!done) begin
                ptr <= AW'(wrap_inc(32'(ptr), DEPTH));
            end
        end
    end

`ifdef CIRCLE_LIST_RESUME_EN
    logic [AW-1:0] start_q;

    // Resume just past the last hit; a miss leaves the start where it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
        end else if (hit) begin
            start_q <= AW'(wrap_inc(32'(ptr), DEPTH));
        end
    end

    assign start = start_q;
`else
    logic unused_hit;

    assign unused_hit = hit;
    assign start      = '0;
`endif

endmodule

// File: rtl/circle_list_scan_ctrl.sv
// rtl/circle_list_scan_ctrl.sv - ring scan initiator: walks the next token, collects get, reports hit/miss (CIRCLE_LIST_RESUME_EN)
module circle_list_scan_ctrl
    import circle_list_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    circle_list_scan_ctrl_if.slave  bus,
    output logic                    ring_ptr_rst,
    output logic                    ring_ptr_set,
    output logic [AW-1:0]           ring_ptr_addr,
    output logic                    ring_next,
    output logic [DW-1:0]           ring_cmp_data,
    input  logic                    ring_get,
    input  logic [DW-1:0]           ring_cur_data,
    input  logic                    ring_wrap
);

    scan_state_t   state, state_n;
    logic          load, advance, hit, done;
    logic          ready_c, valid_c;
    logic [AW-1:0] start;
    logic          hit_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    // The ring reports wrap-around, but the step count alone ends a scan.
    logic unused_wrap;
    assign unused_wrap = ring_wrap;

    circle_list_ptr_cnt #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .hit     (hit),
        .ptr     (ring_ptr_addr),
        .start   (start),
        .done    (done)
    );

    // State register; reset abandons any scan without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-state strobes; ring_get only counts in CHECK.
    always_comb begin
        state_n      = state;
        ready_c      = 1'b0;
        valid_c      = 1'b0;
        ring_next    = 1'b0;
        ring_ptr_rst = 1'b0;
        ring_ptr_set = 1'b0;
        load         = 1'b0;
        advance      = 1'b0;
        hit          = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    load    = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (start == '0) begin
                    ring_ptr_rst = 1'b1;
                end else begin
                    ring_ptr_set = 1'b1;
                end
                state_n = ST_STEP;
            end
            ST_STEP: begin
                ring_next = 1'b1;
                state_n   = ST_CHECK;
            end
            ST_CHECK: begin
                if (ring_get) begin
                    hit     = 1'b1;
                    state_n = ST_RESP;
                end else begin
                    advance = 1'b1;
                    state_n = done ? ST_RESP : ST_STEP;
                end
            end
            ST_RESP: begin
                valid_c = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Key broadcast and result registers; results hold until the next scan ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_cmp_data <= '0;
            hit_q         <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
        end else begin
            if (load) begin
                ring_cmp_data <= bus.req_key;
            end
            if (hit) begin
                hit_q  <= 1'b1;
                addr_q <= ring_ptr_addr;
                data_q <= ring_cur_data;
            end else if (advance && done) begin
                hit_q  <= 1'b0;
                addr_q <= '0;
                data_q <= '0;
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = valid_c;
    assign bus.rsp_hit   = hit_q;
    assign bus.rsp_addr  = addr_q;
    assign bus.rsp_data  = data_q;

endmodule

// File: tb/tb_circle_list_scan_ctrl.sv
// tb/tb_circle_list_scan_ctrl.sv - scoreboard bench for the ring scan initiator (CIRCLE_LIST_RESUME_EN aware)
module tb_circle_list_scan_ctrl;

    localparam int D  = 16;
    localparam int D2 = 256;
    localparam int DW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    circle_list_scan_ctrl_if #(.DW(DW), .AW(AW)) bus ();
    circle_list_scan_ctrl_if #(.DW(DW), .AW(AW)) bus2 ();

    logic          ptr_rst, ptr_set, nxt, get, wrap;
    logic [AW-1:0] paddr;
    logic [DW-1:0] cmp, cur;
    logic          ptr_rst2, ptr_set2, nxt2, get2, wrap2;
    logic [AW-1:0] paddr2;
    logic [DW-1:0] cmp2, cur2;

    circle_list_scan_ctrl #(.DEPTH(D), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ring_ptr_rst(ptr_rst), .ring_ptr_set(ptr_set), .ring_ptr_addr(paddr),
        .ring_next(nxt), .ring_cmp_data(cmp), .ring_get(get),
        .ring_cur_data(cur), .ring_wrap(wrap)
    );

    circle_list_scan_ctrl #(.DEPTH(D2), .DW(DW), .AW(AW)) dut256 (
        .clk(clk), .rst(rst), .bus(bus2),
        .ring_ptr_rst(ptr_rst2), .ring_ptr_set(ptr_set2), .ring_ptr_addr(paddr2),
        .ring_next(nxt2), .ring_cmp_data(cmp2), .ring_get(get2),
        .ring_cur_data(cur2), .ring_wrap(wrap2)
    );

    typedef struct {
        bit hit;
        int addr;
        int data;
        int lat;
        int steps;
    } exp_t;

    typedef struct {
        int addr;
        int key;
    } vis_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   model_start = 0;
    logic [DW-1:0] cells [D];
    exp_t exp_q[$];
    vis_t visit_q[$];
    int   ld_q[$];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "req_ready"}, bus.req_ready, 1);
        chk({p, "rsp_valid"}, bus.rsp_valid, 0);
        chk({p, "rsp_hit"},   bus.rsp_hit, 0);
        chk({p, "rsp_addr"},  bus.rsp_addr, 0);
        chk({p, "rsp_data"},  bus.rsp_data, 0);
        chk({p, "ring_next"}, nxt, 0);
        chk({p, "ptr_rst"},   ptr_rst, 0);
        chk({p, "ptr_set"},   ptr_set, 0);
        chk({p, "ptr_addr"},  paddr, 0);
        chk({p, "cmp_data"},  cmp, 0);
    endtask

    // Fill the ring with values that avoid both given keys.
    task automatic fill_excl(input int a, input int b);
        for (int i = 0; i < D; i++) begin
            int v;
            v = $urandom_range(0, 255);
            while (v == a || v == b) v = $urandom_range(0, 255);
            cells[i] = DW'(v);
        end
    endtask

    // Reference scan: first matching cell walking from the start pointer, at most D cells.
    task automatic issue(input int key, input bit hold);
        exp_t e;
        int   idx;
        int   n;
        e.hit = 1'b0; e.addr = 0; e.data = 0; e.steps = D; e.lat = 2 * D + 2;
        for (int i = 0; i < D; i++) begin
            idx = (model_start + i) % D;
            visit_q.push_back('{idx, key});
            if (int'(cells[idx]) == key) begin
                e.hit = 1'b1; e.addr = idx; e.data = key;
                e.steps = i + 1; e.lat = 2 * (i + 1) + 2;
                break;
            end
        end
        ld_q.push_back(model_start);
`ifdef CIRCLE_LIST_RESUME_EN
        if (e.hit) model_start = (e.addr + 1) % D;
`endif
        exp_q.push_back(e);
        bus.req_key   = DW'(key);
        bus.req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 500) break;
        end
        if (n > 500) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("scan_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Cycle counter for latency measurement.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ring cells: answer one cycle after ring_next, garbage on ring_get otherwise.
    initial begin
        logic          pend;
        logic [AW-1:0] pa;
        logic [DW-1:0] pk;
        get = 1'b0; cur = '0; wrap = 1'b0;
        forever begin
            @(negedge clk);
            pend = nxt; pa = paddr; pk = cmp;
            @(posedge clk); #1;
            wrap = 1'($urandom_range(0, 1));
            if (pend) begin
                cur = cells[int'(pa) % D];
                get = (cur == pk);
            end else begin
                get = 1'($urandom_range(0, 1));
                cur = DW'($urandom_range(0, 255));
            end
        end
    end

    // Monitor: pops expected loads, visits and responses when the DUT presents them.
    int            acc_c, steps;
    bit            busy, prev_rsp;
    logic          last_hit;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    initial forever begin
        exp_t e;
        vis_t v;
        int   s;
        @(negedge clk);
        if (!mon_en) begin
            busy = 0; prev_rsp = 0; steps = 0;
            last_hit = 0; last_addr = '0; last_data = '0;
        end else begin
            if (prev_rsp) chk("ready_after_rsp", bus.req_ready, 1);
            else if (busy) chk("ready_busy", bus.req_ready, 0);
            if (nxt) begin
                steps++;
                if (visit_q.size() == 0) chk("visit_unexpected", 1, 0);
                else begin
                    v = visit_q.pop_front();
                    chk("visit_addr", paddr, v.addr);
                    chk("visit_key", cmp, v.key);
                end
            end
            if (ptr_rst || ptr_set) begin
                if (ld_q.size() == 0) chk("load_unexpected", 1, 0);
                else begin
                    s = ld_q.pop_front();
                    chk("load_rst", ptr_rst, s == 0);
                    chk("load_set", ptr_set, s != 0);
                    if (s != 0) chk("load_addr", paddr, s);
                end
            end
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp_hit", bus.rsp_hit, e.hit);
                    chk("rsp_addr", bus.rsp_addr, e.addr);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_latency", cyc - acc_c, e.lat);
                    chk("rsp_steps", steps, e.steps);
                end
                busy = 0;
                last_hit = bus.rsp_hit; last_addr = bus.rsp_addr; last_data = bus.rsp_data;
            end else begin
                chk("rsp_hold", {bus.rsp_hit, bus.rsp_addr, bus.rsp_data},
                    {last_hit, last_addr, last_data});
            end
            prev_rsp = bus.rsp_valid;
            if (bus.req_valid && bus.req_ready) begin
                acc_c = cyc; steps = 0; busy = 1;
            end
        end
    end

    initial begin
        int  n, c0, pulses, bad, k1, k2;
        bit  seen, fin;
        bus.req_valid = 1'b0; bus.req_key = '0;
        bus2.req_valid = 1'b0; bus2.req_key = '0;
        get2 = 1'b0; cur2 = '0; wrap2 = 1'b0;
        fill_excl(-1, -1);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset_");
        rst = 1'b0;

        // Reset while in CHECK at pointer 5 drops the scan.
        fill_excl(8'h77, -1);
        cells[10] = 8'h77;
        bus.req_key = 8'h77; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!(nxt && paddr == 5) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_rst_reach_ptr5", n < 40, 1);
        @(posedge clk); #1;
        chk("mid_rst_check_ptr", paddr, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_vals("mid_rst_");
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        chk("mid_rst_no_rsp", seen, 0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed: hit at cell 3, full miss, then hit at 14 followed by cell 1.
        fill_excl(8'hA5, -1);
        cells[3] = 8'hA5;
        issue(8'hA5, 0);
        wait_idle();
        fill_excl(8'h3C, -1);
        issue(8'h3C, 0);
        wait_idle();
        fill_excl(8'h11, 8'h22);
        cells[14] = 8'h11;
        cells[1]  = 8'h22;
        issue(8'h11, 0);
        wait_idle();
        issue(8'h22, 0);
        wait_idle();

        // Back-to-back with req_valid held high across both scans.
        fill_excl(-1, -1);
        issue(int'(cells[2]), 1);
        issue(int'(cells[7]), 0);
        wait_idle();

        // Randomized traffic, some back-to-back pairs.
        repeat (40) begin
            for (int i = 0; i < D; i++) cells[i] = DW'($urandom_range(0, 255));
            k1 = $urandom_range(0, 1) ? int'(cells[$urandom_range(0, D-1)]) : $urandom_range(0, 255);
            k2 = $urandom_range(0, 1) ? int'(cells[$urandom_range(0, D-1)]) : $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) begin
                issue(k1, 1);
                issue(k2, 0);
            end else begin
                issue(k1, 0);
            end
            wait_idle();
        end

        // DEPTH=256 miss: 256 steps, pointer 0..255, response at cycle 514.
        bus2.req_key = 8'h3C; bus2.req_valid = 1'b1;
        @(negedge clk);
        chk("d256_ready", bus2.req_ready, 1);
        c0 = cyc;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        pulses = 0; bad = 0; fin = 0; n = 0;
        while (!fin && n < 2000) begin
            @(negedge clk);
            n++;
            if (nxt2) begin
                if (int'(paddr2) != pulses) bad++;
                pulses++;
            end
            if (bus2.rsp_valid) fin = 1;
        end
        chk("d256_timeout", fin, 1);
        chk("d256_latency", cyc - c0, 2 * D2 + 2);
        chk("d256_steps", pulses, D2);
        chk("d256_ptr_seq_bad", bad, 0);
        chk("d256_hit", bus2.rsp_hit, 0);
        chk("d256_addr", bus2.rsp_addr, 0);
        chk("d256_data", bus2.rsp_data, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/circle_list_scan_ctrl.md
# circle_list_scan_ctrl

Initiator for the circular-list register ring: accepts a search key, walks a one-hot "next" token around the ring one cell per step, and collects the cell's "get" (match) answer. It drives the ring's pointer-reset, pointer-set and compare-data inputs, and returns hit/miss plus the matching cell address to the controller. It sits between the controller's lookup port and the ring of list cells, at the token-injecting end of the next/get chain.

## Interface
- DEPTH, 16: number of cells in the ring (2..256).
- DW, 8: key/data width.
- AW, 8: pointer width; DEPTH ≤ 2^AW.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request present.
- req_ready  out  1  controller may present a request; high only in IDLE.
- req_key  in  DW  key to search for; sampled on the req_valid && req_ready cycle.
- rsp_valid  out  1  one-cycle pulse: the result is valid.
- rsp_hit  out  1  a match was found; valid with rsp_valid.
- rsp_addr  out  AW  matching cell index; 0 on a miss.
- rsp_data  out  DW  ring_cur_data captured at the hit; 0 on a miss.
- ring_ptr_rst  out  1  one-cycle pulse: ring pointer to cell 0.
- ring_ptr_set  out  1  one-cycle pulse: ring pointer to ring_ptr_addr.
- ring_ptr_addr  out  AW  current scan pointer.
- ring_next  out  1  token: the cell at the pointer evaluates this cycle.
- ring_cmp_data  out  DW  registered key broadcast to the cells.
- ring_get  in  1  match from the evaluated cell; arrives exactly 1 cycle after ring_next.
- ring_cur_data  in  DW  data of the evaluated cell, aligned with ring_get.
- ring_wrap  in  1  ring transmigration flag; informational only.

## Operation
- States: IDLE, LOAD, STEP, CHECK, RESP.
- IDLE:
  - req_ready=1.
  - On the handshake: latch the key into ring_cmp_data, set the start pointer, and clear the step counter.
  - Go to LOAD.
- LOAD:
  - Pulse ring_ptr_set with ring_ptr_addr = start pointer. When the start pointer is 0, pulse ring_ptr_rst instead.
  - Go to STEP.
- STEP: assert ring_next for one cycle. Go to CHECK.
- CHECK:
  - Sample ring_get.
  - If ring_get=1: capture rsp_addr = ring_ptr_addr and rsp_data = ring_cur_data, set rsp_hit=1, go to RESP.
  - Else increment the step counter. If the counter reaches DEPTH, the scan is a miss (rsp_hit=0): go to RESP.
  - Else advance the pointer with wrap: (DEPTH-1) → 0, never DEPTH. Go to STEP.
- RESP: pulse rsp_valid for one cycle. Go to IDLE.
- Step counter: AW+1 bits, so that DEPTH=256 does not overflow.
- ring_wrap is not used for termination. The step count alone bounds the scan to exactly DEPTH cells.
- A ring_get outside CHECK is ignored.
- req_valid held high during a scan is not accepted until the scan returns to IDLE.
- rst in any state: return to IDLE next edge, drop any scan in progress, emit no rsp_valid.

## Timing
- Reset values:
  - req_ready=1.
  - rsp_valid=0, rsp_hit=0, rsp_addr=0, rsp_data=0.
  - ring_next=0, ring_ptr_rst=0, ring_ptr_set=0.
  - ring_ptr_addr=0, ring_cmp_data=0.
- Hit on the k-th evaluated cell (k=1..DEPTH): rsp_valid asserts 2k+2 cycles after the accept edge.
- Miss: rsp_valid asserts 2·DEPTH+2 cycles after the accept edge.
- Earliest next accept: the cycle after rsp_valid.
- rsp_hit, rsp_addr and rsp_data hold their values until the next rsp_valid.

## Configuration
- CIRCLE_LIST_RESUME_EN defined:
  - After a hit, the next scan starts at (hit_addr+1) mod DEPTH.
  - After a miss, the start pointer is unchanged.
  - rst clears the start pointer to 0.
  - rsp_addr remains an absolute cell index.
- Undefined: every scan starts at cell 0 and LOAD always uses ring_ptr_rst.

## Structure
- Shared package circle_list_pkg holds:
  - the FSM state encoding;
  - defaults for DEPTH, DW and AW;
  - a function for the wrapped pointer increment.
- One sub-module, circle_list_ptr_cnt, is natural. It contains the wrapping pointer, the step counter and the optional resume register, with load, advance and done outputs.

## Test plan
- Reset mid-scan: rst asserted in CHECK with ptr=5 → next cycle IDLE, req_ready=1, all outputs at reset values, no rsp_valid.
- Hit at cell 3, DEPTH=16, key 0xA5: get at the 4th CHECK → rsp_hit=1, rsp_addr=3, rsp_data=0xA5, rsp_valid exactly 10 cycles after accept.
- Miss, key 0x3C absent: exactly 16 ring_next pulses, ptr sequence 0..15 → rsp_hit=0, rsp_addr=0, rsp_valid 34 cycles after accept.
- Wrap with CIRCLE_LIST_RESUME_EN: hit at 14, then key present only in cell 1 → second scan visits 15, 0, 1, reports rsp_addr=1 after 3 steps.
- Back-to-back: req_valid held high across two scans → second accept the cycle after the first rsp_valid; spurious ring_get during STEP and IDLE ignored.
- DEPTH=256, AW=8 miss → 256 steps, no counter overflow, rsp_valid at cycle 514.
